// File: rtl/tlb_op_ctrl.sv
// Sequencer for TLB maintenance instructions (tlbp/tlbr/tlbwi) issued from WB.
// Steps through search/read/write, commits results to CP0 and redirects fetch.
module tlb_op_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        op_valid,
    input  logic [1:0]  op_type,
    input  logic [31:0] op_pc,
    input  logic [31:0] entryhi,
    input  logic [3:0]  index_in,
    input  logic        ex_flush,
    output logic        op_ready,
    output logic        busy,
    output logic [18:0] s1_vpn2,
    output logic [7:0]  s1_asid,
    input  logic        s1_found,
    input  logic [3:0]  s1_index,
    output logic [3:0]  r_index,
    output logic        tlb_we,
    output logic [3:0]  w_index,
    output logic        cp0_index_we,
    output logic [31:0] cp0_index_wdata,
    output logic        cp0_tlbr_we,
    output logic        refetch_valid,
    output logic [31:0] refetch_pc,
    input  logic        refetch_ready
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SEARCH  = 3'd1,
        READ    = 3'd2,
        WRITE   = 3'd3,
        COMMIT  = 3'd4,
        REFETCH = 3'd5
    } state_t;

    localparam logic [1:0] OP_TLBP  = 2'b00;
    localparam logic [1:0] OP_TLBR  = 2'b01;
    localparam logic [1:0] OP_TLBWI = 2'b10;
    localparam logic [1:0] OP_RSVD  = 2'b11;

    state_t      state;
    logic [1:0]  op_type_r;
    logic [31:0] pc_r;
    logic        accept;
    logic        unused_entryhi;

    assign accept         = (state == IDLE) && op_valid && !ex_flush && (op_type != OP_RSVD);
    assign unused_entryhi = ^entryhi[12:8];

    // Outputs are registered: each is loaded on the edge that enters the state that owns it.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state           <= IDLE;
            op_type_r       <= 2'b00;
            pc_r            <= 32'd0;
            op_ready        <= 1'b1;
            busy            <= 1'b0;
            s1_vpn2         <= 19'd0;
            s1_asid         <= 8'd0;
            r_index         <= 4'd0;
            tlb_we          <= 1'b0;
            w_index         <= 4'd0;
            cp0_index_we    <= 1'b0;
            cp0_index_wdata <= 32'd0;
            cp0_tlbr_we     <= 1'b0;
            refetch_valid   <= 1'b0;
            refetch_pc      <= 32'd0;
        end else begin
            s1_vpn2         <= 19'd0;
            s1_asid         <= 8'd0;
            r_index         <= 4'd0;
            tlb_we          <= 1'b0;
            w_index         <= 4'd0;
            cp0_index_we    <= 1'b0;
            cp0_index_wdata <= 32'd0;
            cp0_tlbr_we     <= 1'b0;

            case (state)
                IDLE: begin
                    if (accept) begin
                        op_type_r <= op_type;
                        pc_r      <= op_pc;
                        op_ready  <= 1'b0;
                        busy      <= 1'b1;
                        case (op_type)
                            OP_TLBP: begin
                                state   <= SEARCH;
                                s1_vpn2 <= entryhi[31:13];
                                s1_asid <= entryhi[7:0];
                            end
                            OP_TLBR: begin
                                state   <= READ;
                                r_index <= index_in;
                            end
                            default: begin
                                state   <= WRITE;
                                tlb_we  <= 1'b1;
                                w_index <= index_in;
                            end
                        endcase
                    end
                end
                SEARCH: begin
                    state           <= COMMIT;
                    cp0_index_we    <= 1'b1;
                    cp0_index_wdata <= {~s1_found, 27'd0, s1_found ? s1_index : 4'd0};
                end
                READ: begin
                    state       <= COMMIT;
                    cp0_tlbr_we <= 1'b1;
                end
                WRITE: begin
                    state         <= REFETCH;
                    refetch_valid <= 1'b1;
                    refetch_pc    <= pc_r + 32'd4;
                end
                COMMIT: begin
                    if (op_type_r == OP_TLBR) begin
                        state         <= REFETCH;
                        refetch_valid <= 1'b1;
                        refetch_pc    <= pc_r + 32'd4;
                    end else begin
                        state    <= IDLE;
                        op_ready <= 1'b1;
                        busy     <= 1'b0;
                    end
                end
                REFETCH: begin
                    if (refetch_ready) begin
                        state         <= IDLE;
                        op_ready      <= 1'b1;
                        busy          <= 1'b0;
                        refetch_valid <= 1'b0;
                        refetch_pc    <= 32'd0;
                    end
                end
                default: begin
                    state         <= IDLE;
                    op_ready      <= 1'b1;
                    busy          <= 1'b0;
                    refetch_valid <= 1'b0;
                    refetch_pc    <= 32'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// Vector-table bench for tlb_op_ctrl: each record is one clock cycle of inputs and
// the outputs expected during that cycle, generated from per-operation timelines.
module tb_tlb_op_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        op_valid;
    logic [1:0]  op_type;
    logic [31:0] op_pc;
    logic [31:0] entryhi;
    logic [3:0]  index_in;
    logic        ex_flush;
    logic        op_ready;
    logic        busy;
    logic [18:0] s1_vpn2;
    logic [7:0]  s1_asid;
    logic        s1_found;
    logic [3:0]  s1_index;
    logic [3:0]  r_index;
    logic        tlb_we;
    logic [3:0]  w_index;
    logic        cp0_index_we;
    logic [31:0] cp0_index_wdata;
    logic        cp0_tlbr_we;
    logic        refetch_valid;
    logic [31:0] refetch_pc;
    logic        refetch_ready;

    tlb_op_ctrl dut (
        .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type), .op_pc(op_pc),
        .entryhi(entryhi), .index_in(index_in), .ex_flush(ex_flush), .op_ready(op_ready),
        .busy(busy), .s1_vpn2(s1_vpn2), .s1_asid(s1_asid), .s1_found(s1_found),
        .s1_index(s1_index), .r_index(r_index), .tlb_we(tlb_we), .w_index(w_index),
        .cp0_index_we(cp0_index_we), .cp0_index_wdata(cp0_index_wdata),
        .cp0_tlbr_we(cp0_tlbr_we), .refetch_valid(refetch_valid), .refetch_pc(refetch_pc),
        .refetch_ready(refetch_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        chk;
        logic        rstn;
        logic        v;
        logic [1:0]  t;
        logic [31:0] pc;
        logic [31:0] ehi;
        logic [3:0]  idx;
        logic        flush;
        logic        found;
        logic [3:0]  sidx;
        logic        rready;
        logic        e_ready;
        logic        e_busy;
        logic [18:0] e_vpn2;
        logic [7:0]  e_asid;
        logic [3:0]  e_ridx;
        logic        e_twe;
        logic [3:0]  e_widx;
        logic        e_iwe;
        logic [31:0] e_iwdata;
        logic        e_rwe;
        logic        e_rv;
        logic [31:0] e_rpc;
    } vec_t;

    vec_t vecs[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   cur         = 0;

    // An idle cycle: op_valid low, everything else random noise the DUT must ignore.
    function automatic vec_t idle_vec();
        vec_t v;
        v.chk = 1'b1;  v.rstn = 1'b1;
        v.v = 1'b0;    v.t = 2'($urandom);  v.pc = $urandom;  v.ehi = $urandom;
        v.idx = 4'($urandom);  v.flush = 1'($urandom);
        v.found = 1'($urandom);  v.sidx = 4'($urandom);  v.rready = 1'($urandom);
        v.e_ready = 1'b1;  v.e_busy = 1'b0;
        v.e_vpn2 = '0;  v.e_asid = '0;  v.e_ridx = '0;  v.e_twe = 1'b0;  v.e_widx = '0;
        v.e_iwe = 1'b0;  v.e_iwdata = '0;  v.e_rwe = 1'b0;  v.e_rv = 1'b0;  v.e_rpc = '0;
        return v;
    endfunction

    function automatic vec_t busy_vec();
        vec_t v;
        v = idle_vec();
        v.v = 1'($urandom);
        v.e_ready = 1'b0;
        v.e_busy = 1'b1;
        return v;
    endfunction

    // Builds the cycle timeline of one op presented in an idle cycle; abort_k > 0 pulls
    // resetn low during the abort_k-th cycle after the accept.
    task automatic gen_op(input logic [1:0] t, input logic flush, input logic [31:0] pc,
                          input logic [31:0] ehi, input logic [3:0] idx, input logic found,
                          input logic [3:0] sidx, input int rdelay, input int abort_k);
        vec_t seq[$];
        vec_t b;
        b = idle_vec();
        b.v = 1'b1;  b.t = t;  b.pc = pc;  b.ehi = ehi;  b.idx = idx;  b.flush = flush;
        seq.push_back(b);
        if (!flush && t != 2'b11) begin
            if (t == 2'b00) begin
                b = busy_vec();
                b.e_vpn2 = ehi[31:13];  b.e_asid = ehi[7:0];
                b.found = found;  b.sidx = sidx;
                seq.push_back(b);
                b = busy_vec();
                b.e_iwe = 1'b1;
                b.e_iwdata = found ? 32'(sidx) : 32'h8000_0000;
                seq.push_back(b);
            end else if (t == 2'b01) begin
                b = busy_vec();  b.e_ridx = idx;  seq.push_back(b);
                b = busy_vec();  b.e_rwe = 1'b1;  seq.push_back(b);
            end else begin
                b = busy_vec();  b.e_twe = 1'b1;  b.e_widx = idx;  seq.push_back(b);
            end
            if (t != 2'b00) begin
                for (int d = 0; d <= rdelay; d++) begin
                    b = busy_vec();
                    b.rready = (d == rdelay);
                    b.e_rv = 1'b1;
                    b.e_rpc = pc + 32'd4;
                    seq.push_back(b);
                end
            end
        end
        if (abort_k > 0 && abort_k < seq.size()) begin
            while (seq.size() > abort_k + 1) void'(seq.pop_back());
            seq[abort_k].rstn = 1'b0;
        end
        foreach (seq[i]) vecs.push_back(seq[i]);
    endtask

    task automatic applyStimulus(input vec_t v);
        resetn        = v.rstn;
        op_valid      = v.v;
        op_type       = v.t;
        op_pc         = v.pc;
        entryhi       = v.ehi;
        index_in      = v.idx;
        ex_flush      = v.flush;
        s1_found      = v.found;
        s1_index      = v.sidx;
        refetch_ready = v.rready;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at vector %0d: got %h, expected %h", name, cur, act, exp);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        if (!v.chk) return;
        vectors++;
        check("op_ready",        32'(op_ready),      32'(v.e_ready));
        check("busy",            32'(busy),          32'(v.e_busy));
        check("s1_vpn2",         32'(s1_vpn2),       32'(v.e_vpn2));
        check("s1_asid",         32'(s1_asid),       32'(v.e_asid));
        check("r_index",         32'(r_index),       32'(v.e_ridx));
        check("tlb_we",          32'(tlb_we),        32'(v.e_twe));
        check("w_index",         32'(w_index),       32'(v.e_widx));
        check("cp0_index_we",    32'(cp0_index_we),  32'(v.e_iwe));
        check("cp0_index_wdata", cp0_index_wdata,    v.e_iwdata);
        check("cp0_tlbr_we",     32'(cp0_tlbr_we),   32'(v.e_rwe));
        check("refetch_valid",   32'(refetch_valid), 32'(v.e_rv));
        check("refetch_pc",      refetch_pc,         v.e_rpc);
    endtask

    initial begin
        vec_t v;
        int   t;
        resetn = 1'b0;  op_valid = 1'b0;  op_type = 2'b00;  op_pc = '0;  entryhi = '0;
        index_in = '0;  ex_flush = 1'b0;  s1_found = 1'b0;  s1_index = '0;  refetch_ready = 1'b0;

        v = idle_vec();  v.chk = 1'b0;  v.rstn = 1'b0;  vecs.push_back(v);
        vecs.push_back(idle_vec());

        gen_op(2'b00, 1'b0, 32'h8000_1000, 32'h1234_60A5, 4'd3, 1'b1, 4'd7, 0, 0);
        gen_op(2'b00, 1'b0, 32'h8000_1004, 32'hFFFF_E0FF, 4'd2, 1'b0, 4'd9, 0, 0);
        gen_op(2'b10, 1'b0, 32'hBFC0_0100, 32'h0000_2001, 4'd5, 1'b0, 4'd0, 3, 0);
        gen_op(2'b01, 1'b0, 32'hFFFF_FFFC, 32'h0004_0033, 4'd9, 1'b0, 4'd0, 1, 0);
        gen_op(2'b10, 1'b1, 32'h0000_0040, 32'h0000_0000, 4'd1, 1'b0, 4'd0, 0, 0);
        gen_op(2'b00, 1'b1, 32'h0000_0044, 32'h0000_0000, 4'd1, 1'b1, 4'd1, 0, 0);
        gen_op(2'b11, 1'b0, 32'h0000_0048, 32'h0000_0000, 4'd1, 1'b0, 4'd0, 0, 0);
        vecs.push_back(idle_vec());
        gen_op(2'b10, 1'b0, 32'h0000_0100, 32'h0000_0000, 4'd6, 1'b0, 4'd0, 2, 1);
        vecs.push_back(idle_vec());
        vecs.push_back(idle_vec());
        gen_op(2'b01, 1'b0, 32'h0000_0200, 32'h0000_0000, 4'd4, 1'b0, 4'd0, 5, 4);
        vecs.push_back(idle_vec());
        gen_op(2'b00, 1'b0, 32'h0000_0300, 32'hABCD_E012, 4'd4, 1'b1, 4'd8, 0, 1);
        vecs.push_back(idle_vec());

        for (int n = 0; n < 80; n++) begin
            t = $urandom_range(0, 3);
            gen_op(2'(t), ($urandom_range(0, 7) == 0), $urandom, $urandom, 4'($urandom),
                   1'($urandom), 4'($urandom), $urandom_range(0, 4),
                   ($urandom_range(0, 9) == 0) ? $urandom_range(1, 4) : 0);
            if ($urandom_range(0, 3) == 0) vecs.push_back(idle_vec());
        end
        vecs.push_back(idle_vec());

        foreach (vecs[i]) begin
            @(negedge clk);
            cur = i;
            checkOutput(vecs[i]);
            applyStimulus(vecs[i]);
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tlb_op_ctrl.md
TLB_OP_CTRL -- requirements
Module: tlb_op_ctrl

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 resetn  input  1  synchronous, active-low reset.
REQ-003 op_valid  input  1  WB presents a TLB maintenance instruction this cycle.
REQ-004 op_type  input  2  operation: 00 tlbp, 01 tlbr, 10 tlbwi, 11 reserved.
REQ-005 op_pc  input  32  PC of the instruction.
REQ-006 entryhi  input  32  CP0 EntryHi: vpn2 = [31:13], asid = [7:0].
REQ-007 index_in  input  4  CP0 Index[3:0].
REQ-008 ex_flush  input  1  WB exception or eret this cycle.
REQ-009 op_ready  output  1  controller can accept an op; high only in IDLE.
REQ-010 busy  output  1  state != IDLE; the pipeline stalls issue into WB while high.
REQ-011 s1_vpn2, s1_asid  output  19, 8  TLB search port 1 key.
REQ-012 s1_found, s1_index  input  1, 4  TLB search port 1 result.
REQ-013 r_index  output  4  TLB read port index.
REQ-014 tlb_we, w_index  output  1, 4  TLB write strobe and index; entry data comes from CP0.
REQ-015 cp0_index_we, cp0_index_wdata  output  1, 32  tlbp result write to CP0 Index.
REQ-016 cp0_tlbr_we  output  1  CP0 captures TLB read data into EntryHi/EntryLo0/EntryLo1.
REQ-017 refetch_valid, refetch_pc  output  1, 32  fetch redirect request.
REQ-018 refetch_ready  input  1  fetch accepts the redirect.

Function
REQ-019 States: IDLE, SEARCH, READ, WRITE, COMMIT, REFETCH; one-hot or binary encoding.
REQ-020 Accept = IDLE & op_valid & ~ex_flush & op_type != 11.
- On accept: register op_type, op_pc, entryhi[31:13], entryhi[7:0], index_in.
REQ-021 On accept, next state is SEARCH for tlbp, READ for tlbr, WRITE for tlbwi.
REQ-022 Reserved op_type, or op_valid with ex_flush: no accept, stay IDLE, no output pulse.
REQ-023 SEARCH (1 cycle): s1_vpn2/s1_asid driven from the registered values; s1_found/s1_index sampled at the end of the cycle; next state COMMIT.
REQ-024 READ (1 cycle): r_index = registered index; next state COMMIT.
REQ-025 COMMIT (1 cycle):
- tlbp: cp0_index_we = 1, cp0_index_wdata = {~found_r, 27'b0, index_r}, where index_r = 0 if not found; next state IDLE.
- tlbr: cp0_tlbr_we = 1; next state REFETCH.
REQ-026 WRITE (1 cycle): tlb_we = 1, w_index = registered index; next state REFETCH.
REQ-027 REFETCH:
- refetch_valid = 1, refetch_pc = registered op_pc + 4 (32-bit, wraps modulo 2^32).
- Hold both until refetch_ready; the cycle refetch_ready = 1 is the last REFETCH cycle; next state IDLE.
REQ-028 All strobes (tlb_we, cp0_index_we, cp0_tlbr_we) are single-cycle pulses, asserted only in their state.
REQ-029 Latency from the accept cycle:
- tlbp: strobe in cycle +2, op_ready in cycle +3.
- tlbwi: tlb_we in cycle +1, refetch_valid from cycle +2.
- tlbr: cp0_tlbr_we in cycle +2, refetch_valid from cycle +3.
REQ-030 ex_flush while busy is ignored; an accepted op always completes.
REQ-031 op_valid/op_type changes while busy have no effect on registered values.
REQ-032 Outputs not named active in the current state are 0: s1_*, r_index, w_index, wdata buses, refetch_pc.
REQ-033 Back-to-back: an op presented in the cycle after return to IDLE is accepted; no idle bubble is required.

Reset
REQ-034 resetn = 0 at a rising edge: state IDLE and all registers cleared; next cycle busy = 0, op_ready = 1, all strobes and refetch_valid = 0.
REQ-035 Reset mid-operation (any state, including REFETCH waiting) aborts with no further strobes.

Verification
REQ-036 tlbp, entryhi = 0x12346_0A5, s1_found = 1, s1_index = 7 -> cp0_index_we pulse at +2 with wdata 0x00000007; op_ready = 1 at +3.
REQ-037 tlbp with s1_found = 0 -> cp0_index_wdata = 0x80000000; no refetch.
REQ-038 tlbwi, index_in = 5, op_pc = 0xBFC00100, refetch_ready tied low for 3 cycles -> tlb_we pulse at +1 with w_index = 5; refetch_valid held 4 cycles with pc 0xBFC00104; busy clears after ack.
REQ-039 tlbr, index_in = 9, op_pc = 0xFFFFFFFC -> r_index = 9 at +1; cp0_tlbr_we at +2; refetch_pc = 0x00000000.
REQ-040 op_valid with ex_flush = 1 -> not accepted. Reserved op_type -> not accepted. op_valid while busy -> ignored. resetn low during WRITE -> no refetch_valid afterwards.
